// File: rtl/opll_slot_param_sequencer.sv
// opll_slot_param_sequencer
// Host register file, 18-slot x 4-stage time-multiplex sequencer and
// per-slot voice parameter fetch/decode feeding the VM2413 envelope generator.
// Optional feature: define VM2413_RHYTHM_EN to enable rhythm mode ($0E decode,
// rhythm voices 16..18 on channels 6..8, rhythm key mapping).

module opll_slot_param_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkena,
    input  logic        cpu_we,
    input  logic        cpu_a,
    input  logic [7:0]  cpu_d,
    output logic [4:0]  rom_addr,
    input  logic [63:0] rom_data,
    output logic [4:0]  slot,
    output logic [1:0]  stage,
    output logic        rhythm,
    output logic        am,
    output logic        key,
    output logic [6:0]  tl,
    output logic [3:0]  ar,
    output logic [3:0]  dr,
    output logic [3:0]  sl,
    output logic [3:0]  rr,
    output logic [3:0]  rks
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,   // rom_addr presented
        ST_SELECT = 2'd1,   // voice selected, parameters captured
        ST_EG     = 2'd2,   // envelope generator update
        ST_SPARE  = 2'd3    // next slot's ROM index computed
    } stage_e;

    stage_e      stage_q, stage_d;
    logic [4:0]  slot_q, slot_d;
    logic [4:0]  rom_addr_q, rom_addr_d;

    logic [7:0]  addr_q;
    logic [7:0]  user_q   [8];
    logic [7:0]  fnum_q   [9];
    logic [5:0]  ctrl_q   [9];
    logic [7:0]  insvol_q [9];
`ifdef VM2413_RHYTHM_EN
    logic [5:0]  rhy_q;
`endif
    logic        rhy_en;
    logic [4:0]  rhy_keys;

    logic [6:0]  tl_q, tl_d;
    logic [3:0]  ar_q, ar_d;
    logic [3:0]  dr_q, dr_d;
    logic [3:0]  sl_q, sl_d;
    logic [3:0]  rr_q, rr_d;
    logic [3:0]  rks_q, rks_d;
    logic        key_q, key_d;
    logic        am_q, am_d;
    logic        rhythm_q, rhythm_d;

    logic [3:0]  cur_ch;
    logic [3:0]  next_ch;
    logic        capture;
    logic [63:0] voice;
    logic [7:0]  mode_byte;
    logic [5:0]  ctrl_cur;
    logic [7:0]  insvol_cur;
    logic [3:0]  ar_v, dr_v, sl_v, rr_v;
    logic        rk;
    logic        unused_bits;

`ifdef VM2413_RHYTHM_EN
    assign rhy_en   = rhy_q[5];
    assign rhy_keys = rhy_q[5] ? rhy_q[4:0] : 5'b00000;
`else
    assign rhy_en   = 1'b0;
    assign rhy_keys = 5'b00000;
`endif

    assign cur_ch  = slot_q[4:1];
    assign next_ch = slot_d[4:1];
    assign capture = clkena && (stage_q == ST_SELECT);

    // Stage/slot advance: free-running, one stage per clkena, 18 slots.
    always_comb begin
        stage_d = stage_q;
        slot_d  = slot_q;
        if (clkena) begin
            case (stage_q)
                ST_FETCH:  stage_d = ST_SELECT;
                ST_SELECT: stage_d = ST_EG;
                ST_EG:     stage_d = ST_SPARE;
                default: begin
                    stage_d = ST_FETCH;
                    slot_d  = (slot_q == 5'd17) ? 5'd0 : slot_q + 5'd1;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= ST_FETCH;
            slot_q  <= '0;
        end else begin
            stage_q <= stage_d;
            slot_q  <= slot_d;
        end
    end

    // ROM index for the slot about to start; loaded on entry to stage 0 so
    // that rom_data is valid by the stage-1 capture one stage later.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (clkena && (stage_q == ST_SPARE)) begin
            if (rhy_en && (next_ch >= 4'd6))
                rom_addr_d = 5'd10 + {1'b0, next_ch};
            else
                rom_addr_d = {1'b0, insvol_q[next_ch][7:4]};
        end
    end

    // ROM address register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rom_addr_q <= '0;
        else       rom_addr_q <= rom_addr_d;
    end

    // CPU write port: address latch and register map, independent of clkena.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            for (int unsigned i = 0; i < 8; i++) user_q[i] <= '0;
            for (int unsigned i = 0; i < 9; i++) begin
                fnum_q[i]   <= '0;
                ctrl_q[i]   <= '0;
                insvol_q[i] <= '0;
            end
`ifdef VM2413_RHYTHM_EN
            rhy_q <= '0;
`endif
        end else if (cpu_we) begin
            if (!cpu_a) begin
                addr_q <= cpu_d;
            end else begin
                case (addr_q[7:4])
                    4'h0: begin
                        if (!addr_q[3]) user_q[addr_q[2:0]] <= cpu_d;
`ifdef VM2413_RHYTHM_EN
                        else if (addr_q[3:0] == 4'hE) rhy_q <= cpu_d[5:0];
`endif
                    end
                    4'h1: if (addr_q[3:0] < 4'd9) fnum_q[addr_q[3:0]]   <= cpu_d;
                    4'h2: if (addr_q[3:0] < 4'd9) ctrl_q[addr_q[3:0]]   <= cpu_d[5:0];
                    4'h3: if (addr_q[3:0] < 4'd9) insvol_q[addr_q[3:0]] <= cpu_d;
                    default: ;
                endcase
            end
        end
    end

    // Rhythm key bit routed to the slot it drives.
    always_comb begin
        rk = 1'b0;
        case (slot_q)
            5'd12, 5'd13: rk = rhy_keys[4];   // BD
            5'd14:        rk = rhy_keys[0];   // HH
            5'd15:        rk = rhy_keys[3];   // SD
            5'd16:        rk = rhy_keys[2];   // TOM
            5'd17:        rk = rhy_keys[1];   // TC
            default:      rk = 1'b0;
        endcase
    end

    // Voice selection and parameter decode for the current slot.
    // rom_addr_q == 0 only for a melodic channel with inst 0 (rhythm voices
    // are 16..18), so it doubles as the user-voice select for what was fetched.
    always_comb begin
        ctrl_cur   = ctrl_q[cur_ch];
        insvol_cur = insvol_q[cur_ch];
        voice      = (rom_addr_q == 5'd0) ?
                     {user_q[7], user_q[6], user_q[5], user_q[4],
                      user_q[3], user_q[2], user_q[1], user_q[0]} : rom_data;
        mode_byte  = slot_q[0] ? voice[15:8]  : voice[7:0];
        ar_v       = slot_q[0] ? voice[47:44] : voice[39:36];
        dr_v       = slot_q[0] ? voice[43:40] : voice[35:32];
        sl_v       = slot_q[0] ? voice[63:60] : voice[55:52];
        rr_v       = slot_q[0] ? voice[59:56] : voice[51:48];

        if (slot_q[0])
            tl_d = {insvol_cur[3:0], 3'b000};
        else if (rhy_en && ((slot_q == 5'd14) || (slot_q == 5'd16)))
            tl_d = {insvol_cur[7:4], 3'b000};
        else
            tl_d = {voice[21:16], 1'b0};

        ar_d  = ar_v;
        dr_d  = dr_v;
        sl_d  = sl_v;
        rks_d = mode_byte[4] ? {ctrl_cur[3:1], ctrl_cur[0]} : {2'b00, ctrl_cur[3:2]};
        key_d = ctrl_cur[4] | rk;
        if (key_d)
            rr_d = mode_byte[5] ? 4'd0 : rr_v;
        else if (ctrl_cur[5])
            rr_d = 4'd5;
        else
            rr_d = mode_byte[5] ? rr_v : 4'd7;
        am_d     = mode_byte[7];
        rhythm_d = rhy_en;
    end

    assign unused_bits = ^{voice, fnum_q[cur_ch]};

    // Parameter output registers, loaded at the stage-1 capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tl_q     <= '0;
            ar_q     <= '0;
            dr_q     <= '0;
            sl_q     <= '0;
            rr_q     <= '0;
            rks_q    <= '0;
            key_q    <= 1'b0;
            am_q     <= 1'b0;
            rhythm_q <= 1'b0;
        end else if (capture) begin
            tl_q     <= tl_d;
            ar_q     <= ar_d;
            dr_q     <= dr_d;
            sl_q     <= sl_d;
            rr_q     <= rr_d;
            rks_q    <= rks_d;
            key_q    <= key_d;
            am_q     <= am_d;
            rhythm_q <= rhythm_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign slot     = slot_q;
    assign stage    = stage_q;
    assign tl       = tl_q;
    assign ar       = ar_q;
    assign dr       = dr_q;
    assign sl       = sl_q;
    assign rr       = rr_q;
    assign rks      = rks_q;
    assign key      = key_q;
    assign am       = am_q;
    assign rhythm   = rhythm_q;

endmodule

// File: tb/tb_opll_slot_param_sequencer.sv
// Directed bench for opll_slot_param_sequencer with a small voice ROM model.

module tb_opll_slot_param_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clkena;
    logic        cpu_we;
    logic        cpu_a;
    logic [7:0]  cpu_d;
    logic [4:0]  rom_addr;
    logic [63:0] rom_data;
    logic [4:0]  slot;
    logic [1:0]  stage;
    logic        rhythm, am, key;
    logic [6:0]  tl;
    logic [3:0]  ar, dr, sl, rr, rks;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    opll_slot_param_sequencer dut (
        .clk(clk), .reset(reset), .clkena(clkena),
        .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .slot(slot), .stage(stage), .rhythm(rhythm), .am(am), .key(key),
        .tl(tl), .ar(ar), .dr(dr), .sl(sl), .rr(rr), .rks(rks)
    );

    always #5 clk = ~clk;

    // Voice ROM: bytes {b7..b0} in user-register layout.
    function automatic logic [63:0] rom_word(input logic [4:0] idx);
        case (idx)
            5'd5:    rom_word = {8'h68, 8'h27, 8'hC4, 8'hA3, 8'h00, 8'h15, 8'hB0, 8'h00};
            5'd17:   rom_word = {8'h00, 8'h42, 8'h00, 8'hD1, 8'h00, 8'h00, 8'h00, 8'h00};
            default: rom_word = 64'h0;
        endcase
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        cpu_we = 1'b1; cpu_a = 1'b0; cpu_d = a;
        tick();
        cpu_a = 1'b1; cpu_d = d;
        tick();
        cpu_we = 1'b0; cpu_a = 1'b0;
    endtask

    task automatic wait_pos(input int unsigned s, input int unsigned st);
        int unsigned n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!((slot == s) && (stage == st)) && (n < 100));
        check_eq("wait_pos", {slot, stage}, s * 4 + st);
    endtask

    initial begin
        int unsigned es, eslot;
        reset = 1'b1; clkena = 1'b0; cpu_we = 1'b0; cpu_a = 1'b0; cpu_d = '0;
        tick();
        tick();

        // Reset state
        check_eq("rst_slot", slot, 0);
        check_eq("rst_stage", stage, 0);
        check_eq("rst_rom_addr", rom_addr, 0);
        check_eq("rst_params", {tl, ar, dr, sl, rr, rks, key, am, rhythm}, 0);

        // 72-stage sweep with wrap
        reset = 1'b0; clkena = 1'b1;
        es = 0; eslot = 0;
        for (int i = 0; i < 72; i++) begin
            tick();
            if (es == 3) begin
                es = 0;
                eslot = (eslot == 17) ? 0 : eslot + 1;
            end else begin
                es = es + 1;
            end
            check_eq("sweep_pos", {slot, stage}, eslot * 4 + es);
        end
        check_eq("sweep_wrap", {slot, stage}, 0);
        check_eq("sweep_rom_addr", rom_addr, 0);
        // Default regs: key=0, sus=0, EG=0 -> rr decodes to 7
        check_eq("sweep_params", {tl, ar, dr, sl, rks, key, am, rhythm}, 0);
        check_eq("sweep_rr", rr, 7);

        // clkena low: hold position; CPU writes still land
        clkena = 1'b0;
        cpu_write(8'h30, 8'h04);
        cpu_write(8'h20, 8'h10);
        cpu_write(8'h10, 8'h00);
        cpu_write(8'h04, 8'hF2);
        cpu_write(8'h06, 8'h35);
        check_eq("hold_pos", {slot, stage}, 0);
        clkena = 1'b1;

        // User voice on ch0
        wait_pos(0, 2);
        check_eq("s0_ar", ar, 4'hF);
        check_eq("s0_dr", dr, 4'h2);
        check_eq("s0_sl", sl, 4'h3);
        check_eq("s0_rr", rr, 4'h5);
        check_eq("s0_key", key, 1);
        check_eq("s0_tl", tl, 0);
        wait_pos(1, 2);
        check_eq("s1_tl", tl, 7'h20);
        check_eq("s1_key_rr", {key, rr}, {1'b1, 4'h0});

        // ROM voice 5 on ch3, blk=5 fnum8=1
        cpu_write(8'h33, 8'h5A);
        cpu_write(8'h23, 8'h0B);
        wait_pos(6, 0);
        check_eq("s6_rom_addr", rom_addr, 5);
        wait_pos(6, 2);
        check_eq("s6_tl", tl, 7'h2A);
        check_eq("s6_ar_dr_sl", {ar, dr, sl}, 12'hA32);
        check_eq("s6_rr", rr, 7);
        check_eq("s6_rks_ksr0", rks, 2);
        check_eq("s6_am", am, 0);
        wait_pos(7, 0);
        check_eq("s7_rom_addr", rom_addr, 5);
        wait_pos(7, 2);
        check_eq("s7_tl", tl, 7'h50);
        check_eq("s7_ar_dr_sl", {ar, dr, sl}, 12'hC46);
        check_eq("s7_rr", rr, 8);
        check_eq("s7_rks_ksr1", rks, 4'hB);
        check_eq("s7_am_key", {am, key}, 2'b10);
        cpu_write(8'h23, 8'h2B);
        wait_pos(7, 2);
        check_eq("s7_rr_sus", rr, 5);

        // Rhythm: HH on ch7 mod
        cpu_write(8'h37, 8'h30);
        cpu_write(8'h0E, 8'h21);
        wait_pos(14, 0);
`ifdef VM2413_RHYTHM_EN
        check_eq("s14_rom_addr", rom_addr, 17);
`else
        check_eq("s14_rom_addr", rom_addr, 3);
`endif
        wait_pos(14, 2);
`ifdef VM2413_RHYTHM_EN
        check_eq("s14_rhythm", rhythm, 1);
        check_eq("s14_key", key, 1);
        check_eq("s14_tl", tl, 7'h18);
        check_eq("s14_ar_rr", {ar, rr}, 8'hD2);
`else
        check_eq("s14_rhythm", rhythm, 0);
        check_eq("s14_key", key, 0);
        check_eq("s14_tl", tl, 0);
        check_eq("s14_ar_rr", {ar, rr}, 8'h07);
`endif

        // Key write in the same clk as slot-2 capture
        cpu_we = 1'b1; cpu_a = 1'b0; cpu_d = 8'h21;
        tick();
        cpu_we = 1'b0;
        begin
            int unsigned n;
            n = 0;
            while (!((slot == 2) && (stage == 1)) && (n < 100)) begin
                tick();
                n++;
            end
            check_eq("align_s2", {slot, stage}, 2 * 4 + 1);
        end
        cpu_we = 1'b1; cpu_a = 1'b1; cpu_d = 8'h10;
        tick();
        cpu_we = 1'b0; cpu_a = 1'b0;
        check_eq("s2_key_old", key, 0);
        wait_pos(2, 2);
        check_eq("s2_key_new", key, 1);

        // Asynchronous reset mid-slot
        wait_pos(5, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_mid_pos", {slot, stage}, 0);
        check_eq("rst_mid_rom", rom_addr, 0);
        check_eq("rst_mid_params", {tl, ar, dr, sl, rr, rks, key, am, rhythm}, 0);
        tick();
        reset = 1'b0;
        wait_pos(0, 2);
        check_eq("post_rst_key", key, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
